// File: rtl/hw_track_ctrl.sv
// IR line-tracking decoder: sync + debounce per sensor, steering decision, search/stop FSM.
// Optional build macro HW_POLARITY_INV_EN inverts raw sensor bits for white=1 boards.
module hw_track_ctrl #(
    parameter int unsigned N_SENS   = 4,
    parameter int unsigned DEB_CYC  = 16,
    parameter int unsigned LOST_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] hwsignal,
    output logic [2:0]        ctr,
    output logic [N_SENS-1:0] leds_hw,
    output logic              lost
);

    localparam int unsigned HALF   = N_SENS / 2;
    localparam int unsigned CNT_W  = $clog2(DEB_CYC + 1);
    localparam int unsigned TMR_W  = $clog2(LOST_CYC + 1);
    localparam int unsigned CNTS_W = $clog2(HALF + 1);

    localparam logic [2:0] CODE_FWD   = 3'b000;
    localparam logic [2:0] CODE_LEFT  = 3'b101;
    localparam logic [2:0] CODE_RIGHT = 3'b110;
    localparam logic [2:0] CODE_STOP  = 3'b111;

    typedef enum logic [1:0] {ST_TRACK, ST_SEARCH, ST_STOP} state_t;
    typedef enum logic [1:0] {DIR_FWD, DIR_LEFT, DIR_RIGHT} dir_t;

    function automatic logic [2:0] dir_code(input dir_t d);
        case (d)
            DIR_LEFT:  dir_code = CODE_LEFT;
            DIR_RIGHT: dir_code = CODE_RIGHT;
            default:   dir_code = CODE_FWD;
        endcase
    endfunction

    logic [N_SENS-1:0] w_raw;
    logic [N_SENS-1:0] r_sync1;
    logic [N_SENS-1:0] r_sync2;
    logic [N_SENS-1:0] r_filt;
    logic [CNT_W-1:0]  r_cnt [N_SENS];
    logic [N_SENS-1:0] r_leds;
    logic [2:0]        r_ctr;
    logic              r_lost;
    logic [TMR_W-1:0]  r_timer;
    dir_t              r_last_dir;
    state_t            r_state;

    logic [CNTS_W-1:0] w_cnt_l;
    logic [CNTS_W-1:0] w_cnt_r;
    dir_t              w_dir;
    logic              w_all_white;
    state_t            w_state_nxt;
    logic [2:0]        w_ctr_nxt;
    logic              w_lost_nxt;
    logic [TMR_W-1:0]  w_timer_nxt;
    dir_t              w_last_dir_nxt;

`ifdef HW_POLARITY_INV_EN
    assign w_raw = ~hwsignal;
`else
    assign w_raw = hwsignal;
`endif

    // Two-flop synchroniser followed by a per-channel persistence filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int unsigned i = 0; i < N_SENS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < N_SENS; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEB_CYC - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Left/right balance of dark sensors decides the steering direction
    always_comb begin
        w_cnt_l = '0;
        w_cnt_r = '0;
        for (int unsigned i = 0; i < HALF; i++) begin
            w_cnt_r = w_cnt_r + CNTS_W'(r_filt[i]);
        end
        for (int unsigned i = HALF; i < N_SENS; i++) begin
            w_cnt_l = w_cnt_l + CNTS_W'(r_filt[i]);
        end
        if (w_cnt_l > w_cnt_r) begin
            w_dir = DIR_LEFT;
        end else if (w_cnt_r > w_cnt_l) begin
            w_dir = DIR_RIGHT;
        end else begin
            w_dir = DIR_FWD;
        end
        w_all_white = (r_filt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_TRACK;
            r_ctr      <= CODE_FWD;
            r_lost     <= 1'b0;
            r_timer    <= '0;
            r_last_dir <= DIR_FWD;
            r_leds     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctr      <= w_ctr_nxt;
            r_lost     <= w_lost_nxt;
            r_timer    <= w_timer_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_leds     <= r_filt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_TRACK: begin
                if (w_all_white) w_state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (!w_all_white) begin
                    w_state_nxt = ST_TRACK;
                end else if (r_timer == TMR_W'(LOST_CYC - 1)) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!w_all_white) w_state_nxt = ST_TRACK;
            end
            default: w_state_nxt = ST_TRACK;
        endcase
    end

    always_comb begin
        w_ctr_nxt      = r_ctr;
        w_lost_nxt     = r_lost;
        w_timer_nxt    = r_timer;
        w_last_dir_nxt = r_last_dir;
        case (r_state)
            ST_TRACK: begin
                if (!w_all_white) begin
                    w_ctr_nxt      = dir_code(w_dir);
                    w_last_dir_nxt = w_dir;
                end else begin
                    w_timer_nxt = '0;
                    w_ctr_nxt   = dir_code(r_last_dir);
                    w_lost_nxt  = 1'b1;
                end
            end
            ST_SEARCH: begin
                if (!w_all_white) begin
                    w_ctr_nxt   = dir_code(w_dir);
                    w_lost_nxt  = 1'b0;
                    w_timer_nxt = '0;
                end else begin
                    w_ctr_nxt = (r_timer == TMR_W'(LOST_CYC - 1)) ? CODE_STOP : dir_code(r_last_dir);
                    if (r_timer != TMR_W'(LOST_CYC)) begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (!w_all_white) begin
                    w_ctr_nxt   = dir_code(w_dir);
                    w_lost_nxt  = 1'b0;
                    w_timer_nxt = '0;
                end else begin
                    w_ctr_nxt  = CODE_STOP;
                    w_lost_nxt = 1'b1;
                end
            end
            default: begin
                w_ctr_nxt  = CODE_FWD;
                w_lost_nxt = 1'b0;
            end
        endcase
    end

    assign ctr     = r_ctr;
    assign leds_hw = r_leds;
    assign lost    = r_lost;

endmodule

// File: tb/tb_hw_track_ctrl.sv
// Self-checking bench for hw_track_ctrl (N_SENS=4, DEB_CYC=4, LOST_CYC=20).
module tb_hw_track_ctrl;

    localparam int unsigned NS   = 4;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LOST = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] hw_log;
    logic [NS-1:0] hwsignal;
    logic [2:0]    ctr;
    logic [NS-1:0] leds_hw;
    logic          lost;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef HW_POLARITY_INV_EN
    assign hwsignal = ~hw_log;
`else
    assign hwsignal = hw_log;
`endif

    hw_track_ctrl #(.N_SENS(NS), .DEB_CYC(DEB), .LOST_CYC(LOST)) dut (
        .clk(clk), .rst(rst), .hwsignal(hwsignal),
        .ctr(ctr), .leds_hw(leds_hw), .lost(lost)
    );

    always #5 clk = ~clk;

    // Reference model: sensor value seen two edges late, filtered after DEB
    // consecutive disagreeing samples; mode 0=track 1=search 2=stop.
    int          m_mode;
    int          m_search_n;
    int          m_run [NS];
    logic [3:0]  m_f, m_leds, m_pipe0, m_pipe1;
    logic [2:0]  m_ctr, m_last;
    logic        m_lost;

    function automatic logic [2:0] want_code(input logic [3:0] f);
        int l, r;
        l = int'(f[3]) + int'(f[2]);
        r = int'(f[1]) + int'(f[0]);
        if (l > r) return 3'b101;
        if (r > l) return 3'b110;
        return 3'b000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_search_n = 0; m_f = '0; m_leds = '0;
            m_pipe0 = '0; m_pipe1 = '0; m_ctr = 3'b000; m_last = 3'b000; m_lost = 1'b0;
            for (int i = 0; i < NS; i++) m_run[i] = 0;
        end else begin
            logic [2:0] code;
            logic       white;
            code  = want_code(m_f);
            white = (m_f == 4'b0000);
            m_leds = m_f;
            case (m_mode)
                0: if (!white) begin m_ctr = code; m_last = code; end
                   else begin m_mode = 1; m_search_n = 0; m_ctr = m_last; m_lost = 1'b1; end
                1: if (!white) begin m_mode = 0; m_ctr = code; m_lost = 1'b0; end
                   else if (m_search_n == LOST - 1) begin m_mode = 2; m_ctr = 3'b111; end
                   else m_search_n++;
                default: if (!white) begin m_mode = 0; m_ctr = code; m_lost = 1'b0; end
            endcase
            for (int i = 0; i < NS; i++) begin
                if (m_pipe1[i] != m_f[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin m_f[i] = m_pipe1[i]; m_run[i] = 0; end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pipe1 = m_pipe0;
            m_pipe0 = hw_log;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [2:0] ec, input logic [3:0] el, input logic elost);
        chk({name, ".ctr"}, 8'(ctr), 8'(ec));
        chk({name, ".leds"}, 8'(leds_hw), 8'(el));
        chk({name, ".lost"}, 8'(lost), 8'(elost));
    endtask

    typedef struct {
        logic [3:0]  hw;
        int unsigned hold;
        logic [2:0]  ctr;
        logic [3:0]  leds;
        logic        lost;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'b0000, 30, 3'b111, 4'b0000, 1'b1};
        tbl[1] = '{4'b1000, 10, 3'b101, 4'b1000, 1'b0};
        tbl[2] = '{4'b0011, 10, 3'b110, 4'b0011, 1'b0};
        tbl[3] = '{4'b0000, 10, 3'b110, 4'b0000, 1'b1};
        tbl[4] = '{4'b0100, 10, 3'b101, 4'b0100, 1'b0};
        tbl[5] = '{4'b1111, 10, 3'b000, 4'b1111, 1'b0};
        tbl[6] = '{4'b0110, 10, 3'b000, 4'b0110, 1'b0};
        tbl[7] = '{4'b1100, 10, 3'b101, 4'b1100, 1'b0};
        tbl[8] = '{4'b0111, 10, 3'b110, 4'b0111, 1'b0};
        tbl[9] = '{4'b1110, 10, 3'b101, 4'b1110, 1'b0};

        rst = 1'b1;
        hw_log = 4'b0000;
        repeat (3) @(negedge clk);
        chk_out("reset", 3'b000, 4'b0000, 1'b0);

        // Reset release off-line: search forward, stop 20 cycles after entry
        rst = 1'b0;
        @(negedge clk);
        chk_out("search_entry", 3'b000, 4'b0000, 1'b1);
        repeat (19) @(negedge clk);
        chk("search_before_timeout.ctr", 8'(ctr), 8'h00);
        @(negedge clk);
        chk_out("stop", 3'b111, 4'b0000, 1'b1);

        // From STOP, left sensor: visible on the 7th edge counting the sampling edge
        hw_log = 4'b1000;
        repeat (6) @(negedge clk);
        chk_out("latency_before", 3'b111, 4'b0000, 1'b1);
        @(negedge clk);
        chk_out("latency_at", 3'b101, 4'b1000, 1'b0);

        foreach (tbl[k]) begin
            hw_log = tbl[k].hw;
            repeat (tbl[k].hold) @(negedge clk);
            chk_out($sformatf("tbl%0d", k), tbl[k].ctr, tbl[k].leds, tbl[k].lost);
        end

        // Three-cycle glitch must be filtered out
        hw_log = 4'b0110;
        repeat (12) @(negedge clk);
        hw_log = 4'b0001;
        repeat (3) @(negedge clk);
        hw_log = 4'b0110;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk_out($sformatf("glitch%0d", c), 3'b000, 4'b0110, 1'b0);
        end

        // Asynchronous reset while searching with timer at 10
        hw_log = 4'b0011;
        repeat (12) @(negedge clk);
        hw_log = 4'b0000;
        repeat (17) @(negedge clk);
        chk_out("search_t10", 3'b110, 4'b0000, 1'b1);
        #2 rst = 1'b1;
        #1 chk_out("async_rst_search", 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while tracking clears the LEDs too
        hw_log = 4'b1100;
        repeat (12) @(negedge clk);
        chk_out("track_pre_rst", 3'b101, 4'b1100, 1'b0);
        #3 rst = 1'b1;
        #1 chk_out("async_rst_track", 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Randomised segments against the reference model
        for (int s = 0; s < 60; s++) begin
            int unsigned hold;
            hw_log = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 30);
            for (int c = 0; c < int'(hold); c++) begin
                @(negedge clk);
                chk_out("rand", m_ctr, m_leds, m_lost);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hw_track_ctrl.md
Name: hw_track_ctrl

Overview:
Parametrised infrared line-tracking decoder for the smart car. It takes N reflective IR sensor bits (black = 1, white = 0; bit N_SENS-1 is the leftmost sensor) and synchronises and debounces each one. It then decides the steering command and drives the 3-bit `ctr` code into the motor/PWM block, mirroring the filtered sensor states on LEDs. When the line is lost, a search/timeout state machine first searches in the last known direction and then stops the car.

Parameters:
- N_SENS, 4, number of IR sensors; even, 2..8.
- DEB_CYC, 16, consecutive cycles a raw bit must differ from its filtered value before the filtered value updates; must be at least 1.
- LOST_CYC, 50000, cycles spent in SEARCH before entering STOP; must be at least 1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- hwsignal, input, N_SENS, raw IR sensor bits, asynchronous to clk.
- ctr, output, 3, steering command: 3'b000 forward, 3'b101 left, 3'b110 right, 3'b111 stop.
- leds_hw, output, N_SENS, filtered sensor states.
- lost, output, 1, high while in SEARCH or STOP.

Behaviour:
- Reset values (asynchronous, active-high):
  - ctr=3'b000, leds_hw=0, lost=0.
  - Sync flops=0, filtered bits=0, debounce counters=0, lost timer=0.
  - State TRACK, last_dir=FWD.
- Synchroniser: 2-flop chain per bit. The synchronised bit s[i] is valid 2 cycles after a raw change.
- Debounce, per channel:
  - If s[i]==f[i]: cnt[i] is cleared.
  - Otherwise cnt[i] increments. When cnt[i]==DEB_CYC-1 and the bits still differ, f[i]<=s[i] and cnt[i]<=0.
  - Glitches shorter than DEB_CYC cycles never reach f.
  - Counter width is clog2(DEB_CYC+1). The counter never wraps.
- leds_hw <= f every cycle. It updates in the same cycle as the ctr decision.
- End-to-end latency: a raw change held stable appears on leds_hw/ctr 3+DEB_CYC cycles after the first clk edge that samples it.
- Decision (combinational on f):
  - L = count of ones in f[N_SENS-1:N_SENS/2]; R = count of ones in f[N_SENS/2-1:0].
  - dir = LEFT if L>R, RIGHT if R>L, FWD if L==R.
  - all_white = (f==0).
  - all_black (f all ones, crossing/junction) gives FWD.
- FSM, all outputs registered:
  - TRACK:
    - if not all_white: ctr <= code(dir); last_dir <= dir.
    - if all_white: go to SEARCH, timer <= 0, ctr <= code(last_dir), lost <= 1.
  - SEARCH:
    - ctr holds code(last_dir); timer increments.
    - if not all_white: go to TRACK, ctr <= code(dir), lost <= 0, timer <= 0.
    - else if timer==LOST_CYC-1: go to STOP, ctr <= 3'b111.
    - The line-found condition has priority over timeout in the same cycle.
  - STOP:
    - ctr=3'b111, lost=1.
    - if not all_white: go to TRACK, ctr <= code(dir), lost <= 0.
- When last_dir==FWD on entry to SEARCH, the search command is forward (3'b000).
- After reset f==0, so the FSM enters SEARCH on the first cycle and STOP after LOST_CYC cycles unless the line is seen. This is required behaviour: the car stays stationary off-line.
- rst asserted mid-operation returns everything to the reset values immediately, independent of clk.
- Timer width is clog2(LOST_CYC+1). The timer saturates and never wraps.

Optional Feature:
- HW_POLARITY_INV_EN
  - Defined: hwsignal is inverted before the synchroniser, for sensor boards that output white = 1. All downstream logic, leds_hw included, still sees black = 1.
  - Undefined: hwsignal is used as-is.
  - Reset values are identical in both builds.

Test Plan:
(All scenarios use N_SENS=4, DEB_CYC=4, LOST_CYC=20.)
1. Reset release with hwsignal=4'b0000:
   - lost=1 and ctr=3'b000 within 1 cycle.
   - ctr=3'b111 exactly 20 cycles after entering SEARCH.
2. From STOP, hwsignal=4'b1000 held:
   - leds_hw=4'b1000, ctr=3'b101, lost=0 exactly 7 cycles after the first sampling edge.
3. hwsignal=4'b0001 pulse lasting 3 cycles, otherwise 4'b0110:
   - leds_hw stays 4'b0110 and ctr stays 3'b000 (no glitch).
4. In TRACK with hwsignal=4'b0011, then 4'b0000:
   - ctr=3'b110 during SEARCH, then 3'b111 after 20 cycles.
   - Return of 4'b0100 before timeout gives ctr=3'b101 and lost=0.
5. hwsignal=4'b1111 → ctr=3'b000.
   - With HW_POLARITY_INV_EN defined, hwsignal=4'b0111 gives leds_hw=4'b1000 and ctr=3'b101.
6. Assert rst during SEARCH (timer=10) → ctr=3'b000, lost=0, leds_hw=0 asynchronously.
